// File: rtl/bin_conv_acc.sv
// XNOR-popcount binary convolution accumulator with Q4.8 scale/bias, ReLU and
// saturation; emits one 12-bit value per pixel and flags the end of each pooling group.
module bin_conv_acc #(
   parameter int unsigned WORD_W  = 16,
   parameter int unsigned N_WORDS = 9,
   parameter int unsigned N_PIX   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [11:0]       i_scale,
   input  logic [11:0]       i_bias,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WORD_W-1:0] i_act_word,
   input  logic [WORD_W-1:0] i_wt_word,
   output logic [11:0]       o_data_out,
   output logic              o_out_valid,
   output logic              o_end_data,
   output logic              o_busy
);

   localparam int unsigned K      = WORD_W * N_WORDS;
   localparam int unsigned ACC_W  = $clog2(K + 1);
   localparam int unsigned PROD_W = ACC_W + 14;
   localparam int unsigned DOT_W  = ACC_W + 2;
   localparam int unsigned MUL_W  = DOT_W + 13;
   localparam int unsigned SUM_W  = PROD_W + 1;
   localparam int unsigned POP_W  = $clog2(WORD_W + 1);
   localparam int unsigned WC_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int unsigned PC_W   = (N_PIX > 1) ? $clog2(N_PIX) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACC   = 3'd1,
      S_MUL   = 3'd2,
      S_OUT   = 3'd3,
      S_FLUSH = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_accept;
   logic                      w_start_ok;
   logic                      w_last_word;
   logic                      w_last_pix;
   logic [WORD_W-1:0]         w_xnor;
   logic [POP_W-1:0]          w_pop;
   logic signed [DOT_W-1:0]   w_dot;
   logic signed [MUL_W-1:0]   w_mul_full;
   logic signed [SUM_W-1:0]   w_sum;
   logic [11:0]               w_clamp;

   logic [ACC_W-1:0]          r_acc;
   logic [WC_W-1:0]           r_word_cnt;
   logic [PC_W-1:0]           r_pix_cnt;
   logic [11:0]               r_scale;
   logic signed [11:0]        r_bias;
   logic signed [PROD_W-1:0]  r_prod;
   logic [11:0]               r_data_out;
   logic                      r_out_valid;
   logic                      r_end_data;
   logic                      r_in_ready;
   logic                      r_busy;

   assign w_accept    = i_in_valid && r_in_ready;
   assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last_word = (r_word_cnt == WC_W'(N_WORDS - 1));
   assign w_last_pix  = (r_pix_cnt == PC_W'(N_PIX - 1));
   assign w_xnor      = ~(i_act_word ^ i_wt_word);

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < int'(WORD_W); i++) begin
         w_pop = w_pop + POP_W'(w_xnor[i]);
      end
   end

   // Map the match count back to a +/-1 dot product: dot = 2*acc - K.
   assign w_dot      = $signed({1'b0, r_acc, 1'b0}) - $signed(DOT_W'(K));
   assign w_mul_full = MUL_W'(w_dot) * MUL_W'($signed({1'b0, r_scale}));
   assign w_sum      = SUM_W'(r_prod) + SUM_W'(r_bias);

   always_comb begin
      w_clamp = w_sum[11:0];
      if (w_sum[SUM_W-1]) begin
         w_clamp = 12'h000;
      end else if (w_sum > $signed(SUM_W'(4095))) begin
         w_clamp = 12'hFFF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_nxt = S_ACC;
         S_ACC:   if (w_accept && w_last_word) w_state_nxt = S_MUL;
         S_MUL:   w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = w_last_pix ? S_FLUSH : S_ACC;
         S_FLUSH: w_state_nxt = S_DONE;
         S_DONE:  if (w_start_ok) w_state_nxt = S_ACC;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered status outputs, decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_word_cnt  <= '0;
         r_pix_cnt   <= '0;
         r_scale     <= '0;
         r_bias      <= '0;
         r_prod      <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_end_data  <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == S_ACC);
         r_busy      <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE));
         r_end_data  <= (w_state_nxt == S_DONE);
         r_out_valid <= (r_state == S_OUT);
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  r_scale    <= i_scale;
                  r_bias     <= $signed(i_bias);
                  r_acc      <= '0;
                  r_word_cnt <= '0;
                  r_pix_cnt  <= '0;
               end
            end
            S_ACC: begin
               if (w_accept) begin
                  r_acc      <= r_acc + ACC_W'(w_pop);
                  r_word_cnt <= r_word_cnt + WC_W'(1);
               end
            end
            S_MUL: begin
               r_prod <= PROD_W'(w_mul_full);
            end
            S_OUT: begin
               r_data_out <= w_clamp;
               r_acc      <= '0;
               r_word_cnt <= '0;
               r_pix_cnt  <= r_pix_cnt + PC_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_data_out  = r_data_out;
   assign o_out_valid = r_out_valid;
   assign o_end_data  = r_end_data;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_bin_conv_acc.sv
// Directed bench for bin_conv_acc: pixel values, latency, group end, handshake and reset.
module tb_bin_conv_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] scale;
   logic [11:0] bias;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] act;
   logic [15:0] wt;
   logic [11:0] data_out;
   logic        out_valid;
   logic        end_data;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;
   int n_words = 0;
   int n_ov    = 0;

   localparam logic [15:0] ALL1 = 16'hFFFF;
   localparam logic [15:0] ALL0 = 16'h0000;
   localparam logic [15:0] HALF = 16'h00FF;

   always #5 clk = ~clk;

   bin_conv_acc #(.WORD_W(16), .N_WORDS(9), .N_PIX(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (start),
      .i_scale    (scale),
      .i_bias     (bias),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .i_act_word (act),
      .i_wt_word  (wt),
      .o_data_out (data_out),
      .o_out_valid(out_valid),
      .o_end_data (end_data),
      .o_busy     (busy)
   );

   always @(posedge clk) begin
      if (in_valid && in_ready) n_words++;
      if (out_valid) n_ov++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic do_start(input logic [11:0] s, input logic [11:0] b);
      scale = s;
      bias  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_ready", 32'(in_ready), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_end_drop", 32'(end_data), 32'd0);
   endtask

   task automatic send_word(input logic [15:0] a, input logic [15:0] w);
      int n = 0;
      in_valid = 1'b1;
      act      = a;
      wt       = w;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("word_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Feeds 9 words; checks out_valid exactly two cycles after the last accept.
   task automatic run_pixel(input logic [15:0] a, input logic [15:0] w, input int maxgap,
                            input bit hold, input bit last, input logic [11:0] exp,
                            input string tag);
      for (int i = 0; i < 9; i++) begin
         int g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
         repeat (g) @(negedge clk);
         send_word(a, w);
      end
      if (hold) begin
         in_valid = 1'b1;
         act      = 16'h1234;
      end
      @(negedge clk);
      chk({tag, "_ov_early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_ov"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(data_out), 32'(exp));
      chk({tag, "_rdy_after"}, 32'(in_ready), last ? 32'd0 : 32'd1);
   endtask

   task automatic group_end(input logic [11:0] exp_last);
      int hi = 0;
      chk("flush_end", 32'(end_data), 32'd0);
      @(negedge clk);
      chk("done_end", 32'(end_data), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_ready", 32'(in_ready), 32'd0);
      chk("done_ov", 32'(out_valid), 32'd0);
      repeat (20) begin
         @(negedge clk);
         if (end_data) hi++;
      end
      chk("end_held", 32'(hi), 32'd20);
      chk("done_hold_data", 32'(data_out), 32'(exp_last));
   endtask

   initial begin
      int w0;
      int o0;
      rst = 1'b1; start = 1'b0; scale = '0; bias = '0;
      in_valid = 1'b0; act = '0; wt = '0;
      repeat (2) @(negedge clk);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_end", 32'(end_data), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Idle ignores in_valid.
      w0 = n_words;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk("idle_no_accept", 32'(n_words - w0), 32'd0);

      // Group 1: scale 1 LSB, bias 0.
      do_start(12'h001, 12'h000);
      run_pixel(ALL1, ALL1, 0, 1'b0, 1'b0, 12'h090, "g1_match");
      run_pixel(ALL0, ALL1, 0, 1'b0, 1'b0, 12'h000, "g1_relu");
      run_pixel(HALF, ALL1, 0, 1'b0, 1'b0, 12'h000, "g1_half");
      run_pixel(ALL1, ALL1, 0, 1'b0, 1'b1, 12'h090, "g1_match2");
      group_end(12'h090);

      // Group 2: large positive bias.
      do_start(12'h001, 12'h7FF);
      run_pixel(ALL0, ALL1, 0, 1'b0, 1'b0, 12'h76F, "g2_mis");
      run_pixel(ALL1, ALL1, 0, 1'b0, 1'b0, 12'h88F, "g2_match");
      run_pixel(HALF, ALL1, 0, 1'b0, 1'b0, 12'h7FF, "g2_half");
      run_pixel(ALL0, ALL1, 0, 1'b0, 1'b1, 12'h76F, "g2_mis2");
      group_end(12'h76F);

      // Group 3: unity scale, saturation both ways.
      do_start(12'h100, 12'h080);
      run_pixel(HALF, ALL1, 0, 1'b0, 1'b0, 12'h080, "g3_half");
      run_pixel(ALL1, ALL1, 0, 1'b0, 1'b0, 12'hFFF, "g3_sat");
      run_pixel(ALL0, ALL1, 0, 1'b0, 1'b0, 12'h000, "g3_neg");
      run_pixel(HALF, ALL1, 0, 1'b0, 1'b1, 12'h080, "g3_half2");
      group_end(12'h080);

      // Group 4: negative bias, random gaps, in_valid held through MUL/OUT.
      w0 = n_words;
      o0 = n_ov;
      do_start(12'h001, 12'hF80);
      run_pixel(HALF, ALL1, 3, 1'b1, 1'b0, 12'h000, "g4_half");
      run_pixel(ALL1, ALL1, 3, 1'b1, 1'b0, 12'h010, "g4_match");
      run_pixel(ALL0, ALL1, 3, 1'b1, 1'b0, 12'h000, "g4_mis");
      run_pixel(ALL1, ALL1, 3, 1'b1, 1'b1, 12'h010, "g4_match2");
      group_end(12'h010);
      chk("g4_words", 32'(n_words - w0), 32'd36);
      chk("g4_pulses", 32'(n_ov - o0), 32'd4);

      // Reset mid-ACC after 5 words.
      do_start(12'h001, 12'h000);
      for (int i = 0; i < 5; i++) send_word(ALL0, ALL1);
      #2 rst = 1'b1;
      #1;
      chk("arst_data", 32'(data_out), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_end", 32'(end_data), 32'd0);
      chk("arst_ov", 32'(out_valid), 32'd0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wins_busy", 32'(busy), 32'd0);
      chk("rst_wins_ready", 32'(in_ready), 32'd0);

      w0 = n_words;
      do_start(12'h001, 12'h000);
      run_pixel(ALL1, ALL1, 0, 1'b0, 1'b0, 12'h090, "post_rst");
      chk("post_rst_words", 32'(n_words - w0), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
